// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit holding HI/LO, with busy for the hazard unit.
// Optional MDU_CANCEL_EN adds a cancel port that flushes an in-flight operation.
module md_unit #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  mdu_op,
  input  logic        madd,
  input  logic        hilo,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);
  logic [3:0]  cnt;
  logic [63:0] pend, prod, res;
  logic        pend_madd, sgn, div0, ovf;
  logic [31:0] quot, rem;
  always_comb begin
    sgn  = !mdu_op[0];
    prod = {{32{sgn & a[31]}}, a} * {{32{sgn & b[31]}}, b};
    div0 = b == 32'd0;
    // the one signed quotient that does not fit in 32 bits wraps to the dividend
    ovf  = sgn && a == 32'h8000_0000 && &b;
    quot = div0 ? '1 : ovf ? 32'h8000_0000 : mdu_op[0] ? a / b : $unsigned($signed(a) / $signed(b));
    rem  = div0 ? a : ovf ? 32'd0 : mdu_op[0] ? a % b : $unsigned($signed(a) % $signed(b));
    res  = mdu_op[1] ? {rem, quot} : prod;
  end
  assign busy  = cnt != 4'd0;
  assign rdata = hilo ? hi : lo;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      pend      <= '0;
      pend_madd <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end
`ifdef MDU_CANCEL_EN
    else if (cancel) begin
      cnt       <= '0;
      pend      <= '0;
      pend_madd <= 1'b0;
    end
`endif
    else if (cnt == 4'd0) begin
      if (start) begin
        pend      <= res;
        pend_madd <= madd && !mdu_op[1];
        cnt       <= mdu_op[1] ? DIV_CNT : MUL_CNT;
      end else if (we) begin
        if (hilo) hi <= a;
        else lo <= a;
      end
    end else begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) {hi, lo} <= pend_madd ? {hi, lo} + pend : pend;
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: vector table, hand-written corner sequences and random ops against an arithmetic model.
module tb_md_unit;
  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, madd = 1'b0, hilo = 1'b0, we = 1'b0, cancel = 1'b0;
  logic [1:0]  mdu_op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy;
  logic [31:0] hi, lo, rdata;
  int checks = 0, errors = 0;

  md_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mdu_op(mdu_op), .madd(madd),
    .hilo(hilo), .we(we), .a(a), .b(b),
`ifdef MDU_CANCEL_EN
    .cancel(cancel),
`endif
    .busy(busy), .hi(hi), .lo(lo), .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic        m;
    logic [31:0] x, y, ihi, ilo, ehi, elo;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic m, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] acc);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (op[1]) begin
      if (y == 0) return {x, 32'hFFFF_FFFF};
      if (op[0]) return {x % y, x / y};
      q = sx / sy;
      r = sx % sy;
      return {r[31:0], q[31:0]};
    end
    p = op[0] ? 64'(x) * 64'(y) : 64'(sx * sy);
    return m ? acc + p : p;
  endfunction

  task automatic write_reg(input logic h, input logic [31:0] v);
    @(negedge clk);
    we = 1'b1; hilo = h; a = v;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic m, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp);
    int lat;
    lat = op[1] ? 10 : 5;
    @(negedge clk);
    start = 1'b1; mdu_op = op; madd = m; a = x; b = y;
    @(negedge clk);
    start = 1'b0; madd = 1'b0;
    for (int i = 0; i < lat; i++) begin
      check({nm, " busy"}, 64'(busy), 64'd1);
      @(negedge clk);
    end
    check({nm, " busy_done"}, 64'(busy), 64'd0);
    check({nm, " hilo"}, {hi, lo}, exp);
  endtask

  initial begin
    vec_t vt[10];
    logic [63:0] acc, exp;
    logic [1:0]  op;
    logic        m;
    logic [31:0] x, y;
    vt[0] = '{2'b00, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vt[1] = '{2'b01, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd1, 32'hFFFF_FFFE};
    vt[2] = '{2'b10, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[3] = '{2'b10, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd9, 32'd9, 32'd0, 32'h8000_0000};
    vt[4] = '{2'b11, 1'b0, 32'h1234, 32'd0, 32'd0, 32'd0, 32'h1234, 32'hFFFF_FFFF};
    vt[5] = '{2'b00, 1'b1, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0};
    vt[6] = '{2'b10, 1'b0, 32'd7, 32'd0, 32'd0, 32'd0, 32'd7, 32'hFFFF_FFFF};
    vt[7] = '{2'b01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'hFFFF_FFFE, 32'd2};
    vt[8] = '{2'b10, 1'b1, 32'd20, 32'd3, 32'd5, 32'd5, 32'd2, 32'd6};
    vt[9] = '{2'b00, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd5, 32'd0, 32'd4};

    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset hilo", {hi, lo}, 64'd0);
    reset_n = 1'b1;

    foreach (vt[i]) begin
      write_reg(1'b1, vt[i].ihi);
      write_reg(1'b0, vt[i].ilo);
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].m, vt[i].x, vt[i].y, {vt[i].ehi, vt[i].elo});
    end

    // async reset mid-div with counter at 6
    write_reg(1'b1, 32'd55);
    write_reg(1'b0, 32'd66);
    @(negedge clk);
    start = 1'b1; mdu_op = 2'b10; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-reset busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("post-reset mult", 2'b00, 1'b0, 32'd3, 32'd4, 64'd12);

    // start and mthi while a div is running are both ignored
    @(negedge clk);
    start = 1'b1; mdu_op = 2'b10; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("ign busy", 64'(busy), 64'd1);
      start = (i == 2); we = (i == 4); hilo = 1'b1;
      if (i == 2) begin mdu_op = 2'b00; a = 32'd2; b = 32'd2; end
      if (i == 4) a = 32'h5555;
      @(negedge clk);
      start = 1'b0; we = 1'b0;
    end
    check("ign busy_done", 64'(busy), 64'd0);
    check("ign hilo", {hi, lo}, {32'd2, 32'd14});
    @(negedge clk);
    check("ign no restart", 64'(busy), 64'd0);

    // start wins over we in the same idle cycle
    @(negedge clk);
    start = 1'b1; we = 1'b1; hilo = 1'b1; mdu_op = 2'b00; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0; we = 1'b0;
    check("start>we hi", 64'(hi), 64'd2);
    repeat (5) @(negedge clk);
    check("start>we hilo", {hi, lo}, 64'd15);

    write_reg(1'b1, 32'hABCD);
    check("mthi hi", 64'(hi), 64'hABCD);
    hilo = 1'b1; #1;
    check("rdata hi", 64'(rdata), 64'hABCD);
    hilo = 1'b0; #1;
    check("rdata lo", 64'(rdata), 64'd15);

`ifdef MDU_CANCEL_EN
    @(negedge clk);
    start = 1'b1; mdu_op = 2'b11; a = 32'd99; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel busy", 64'(busy), 64'd0);
    repeat (10) @(negedge clk);
    check("cancel hilo", {hi, lo}, {32'hABCD, 32'd15});
    start = 1'b1; cancel = 1'b1; we = 1'b1; a = 32'd1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; we = 1'b0;
    check("cancel>start busy", 64'(busy), 64'd0);
    check("cancel>we hilo", {hi, lo}, {32'hABCD, 32'd15});
`endif

    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      m  = 1'($urandom_range(0, 1));
      x  = (n % 5 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      y  = (n % 7 == 0) ? 32'd0 : (n % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      acc = {$urandom, $urandom};
      write_reg(1'b1, acc[63:32]);
      write_reg(1'b0, acc[31:0]);
      exp = model(op, m, x, y, acc);
      run_op($sformatf("rnd%0d op%0d", n, op), op, m, x, y, exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
